axi_burst_mem: RTL
==================

AXI_BURST_MEM -- requirements
Module: axi_burst_mem

Interface
REQ-001 DATA_W, 32, data bus width in bits (32, 64 or 128).
REQ-002 ADDR_W, 16, byte address width.
REQ-003 ID_W, 4, transaction ID width.
REQ-004 DEPTH, 1024, memory size in DATA_W words (power of two).
REQ-005 aclk  in  1  clock; all logic on rising edge.
REQ-006 arst  in  1  reset, synchronous, active-low.
REQ-007 awid  in  ID_W  write ID.
REQ-008 awaddr  in  ADDR_W  write start byte address.
REQ-009 awlen  in  8  write beats minus 1.
REQ-010 awsize  in  3  log2 bytes per beat.
REQ-011 awburst  in  2  write burst type (0 FIXED, 1 INCR, 2 WRAP, 3 reserved).
REQ-012 awvalid  in  1  / awready  out  1: AW handshake pair.
REQ-013 wdata  in  DATA_W  write data.
REQ-014 wstrb  in  DATA_W/8  byte enables.
REQ-015 wlast  in  1  last write beat marker.
REQ-016 wvalid  in  1  / wready  out  1: W handshake pair.
REQ-017 bid  out  ID_W  / bresp  out  2: write response ID and code.
REQ-018 bvalid  out  1  / bready  in  1: B handshake pair.
REQ-019 arid  in  ID_W  read ID.
REQ-020 araddr  in  ADDR_W  read start byte address.
REQ-021 arlen  in  8  / arsize  in  3  / arburst  in  2: read burst descriptor, same encoding as AW.
REQ-022 arvalid  in  1  / arready  out  1: AR handshake pair.
REQ-023 rid  out  ID_W  / rdata  out  DATA_W  / rresp  out  2  / rlast  out  1: read beat.
REQ-024 rvalid  out  1  / rready  in  1: R handshake pair.

Function
REQ-025 Write FSM: W_IDLE (awready=1) -> W_DATA on AW handshake (latch id/addr/len/size/burst, beat count=0) -> W_RESP after last beat -> W_IDLE on bvalid&&bready.
REQ-026 wready=1 only in W_DATA, first asserted the cycle after the AW handshake; one beat accepted per cycle on wvalid&&wready.
REQ-027 Each accepted beat writes only the bytes with wstrb=1 at word index (addr/(DATA_W/8)) mod DEPTH.
REQ-028 Address update per beat: FIXED unchanged; INCR addr += 2^size; WRAP increments within a window aligned to (awlen+1)*2^size bytes and wraps to the window base.
REQ-029 Beat counter is authoritative: the burst ends on beat awlen+1 whatever wlast says; a wlast mismatch sets bresp=SLVERR (2), data is still written.
REQ-030 bresp=SLVERR and no memory write for awburst=3, for WRAP with awlen not in {1,3,7,15}, for awsize > log2(DATA_W/8), or if any beat address >= DEPTH*DATA_W/8; W beats are still accepted and discarded; otherwise bresp=OKAY (0).
REQ-031 bvalid asserts the cycle after the final beat; bid=latched awid; bvalid, bid and bresp hold stable until bready.
REQ-032 Read FSM: R_IDLE (arready=1) -> R_DATA on AR handshake -> R_IDLE after the beat with rlast=1 is accepted.
REQ-033 The first rvalid occurs the cycle after the AR handshake; the next beat is presented the cycle after each rvalid&&rready (full throughput); rdata/rresp/rlast/rid hold while rvalid&&!rready.
REQ-034 Read addressing follows REQ-028; illegal conditions per REQ-030 return rresp=SLVERR and rdata=0 on every beat; rlast=1 on beat arlen+1 only.
REQ-035 Read and write FSMs are independent and concurrent; one outstanding transaction per direction.
REQ-036 Same-cycle read and write to one word: read returns the pre-write data (read-first).

Reset
REQ-037 While arst=0 at a rising edge: both FSMs go to IDLE; awready=1, arready=1; wready, bvalid, rvalid, rlast=0; bid, bresp, rid, rresp, rdata=0.
REQ-038 Reset mid-burst aborts the burst with no response; memory contents are not cleared; beats already written persist.

Verification
REQ-039 INCR write awaddr=0x10, awlen=3, awsize=2, wdata 0xA0..0xA3 with wstrb=0xF -> bresp=0, bvalid 1 cycle after last beat; INCR read of the same burst returns 0xA0..0xA3 with rlast on beat 4.
REQ-040 WRAP write awaddr=0x38, awlen=3, awsize=2 -> beats land at 0x38, 0x3C, 0x30, 0x34; read-back confirms the order.
REQ-041 Write wstrb=0x3 data 0xFFFFFFFF over word 0x12345678 -> read returns 0x1234FFFF.
REQ-042 awburst=3, or WRAP with awlen=2 -> bresp=2, memory unchanged; an out-of-range araddr -> rresp=2 on every beat, rdata=0.
REQ-043 Hold rready=0 and bready=0 for 5 cycles -> rvalid/rdata and bvalid/bresp stable; a concurrent read and write to one address returns the old data.
REQ-044 Assert arst=0 during beat 2 of an awlen=7 write -> next cycle awready=1, wready=0, bvalid=0; beats 1-2 remain in memory.

Source files
------------

// File: rtl/axi_burst_mem.sv
// axi_burst_mem: AXI-style burst memory slave with independent read and
// write channels, one outstanding transaction per direction.
//
// Ports
//   aclk, arst                    clock (rising edge), synchronous active-low reset
//   aw{id,addr,len,size,burst}    write burst descriptor, awvalid/awready handshake
//   wdata, wstrb, wlast           write beat, wvalid/wready handshake
//   bid, bresp                    write response, bvalid/bready handshake
//   ar{id,addr,len,size,burst}    read burst descriptor, arvalid/arready handshake
//   rid, rdata, rresp, rlast      read beat, rvalid/rready handshake
//
// Bursts: 0 FIXED, 1 INCR, 2 WRAP (len 1/3/7/15 only), 3 reserved.
// Illegal bursts (reserved type, bad WRAP length, oversize beat, or any beat
// outside the array) complete normally with SLVERR, with no memory write and
// zero read data. A read and a write hitting one word in the same cycle
// return the old contents.
module axi_burst_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 1024
) (
  input  logic                  aclk,
  input  logic                  arst,
  input  logic [ID_W-1:0]       awid,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_W-1:0]       bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ID_W-1:0]       arid,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_W-1:0]       rid,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int BYTE_SH = $clog2(STRB_W);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int WIDE_W  = ADDR_W + 16;

  localparam logic [2:0]        MAX_SIZE    = 3'(BYTE_SH);
  localparam logic [WIDE_W-1:0] MEM_BYTES   = WIDE_W'(DEPTH * STRB_W);
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;

  // Word index of a byte address; the truncation supplies the mod DEPTH.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> BYTE_SH);
  endfunction

  // Address of the following beat.
  function automatic logic [ADDR_W-1:0] next_addr(
    input logic [ADDR_W-1:0] a,
    input logic [7:0]        len,
    input logic [2:0]        size,
    input logic [1:0]        burst
  );
    logic [ADDR_W-1:0] bsz;
    logic [ADDR_W-1:0] wmask;
    bsz   = ADDR_W'(1) << size;
    wmask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    case (burst)
      2'd1:    next_addr = a + bsz;
      // Wrap window is (len+1)*2^size bytes, aligned to its own size.
      2'd2:    next_addr = (a & ~wmask) | ((a + bsz) & wmask);
      default: next_addr = a;
    endcase
  endfunction

  // Whole-burst legality, evaluated once from the descriptor. The highest
  // beat address is computed in a wider type so overflow cannot hide it.
  function automatic logic burst_bad(
    input logic [ADDR_W-1:0] a,
    input logic [7:0]        len,
    input logic [2:0]        size,
    input logic [1:0]        burst
  );
    logic [WIDE_W-1:0] top;
    logic [WIDE_W-1:0] wsz;
    logic              len_ok;
    wsz    = (WIDE_W'(len) + WIDE_W'(1)) << size;
    len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    case (burst)
      2'd1:    top = WIDE_W'(a) + (WIDE_W'(len) << size);
      2'd2:    top = (WIDE_W'(a) & ~(wsz - WIDE_W'(1))) + wsz - WIDE_W'(1);
      default: top = WIDE_W'(a);
    endcase
    burst_bad = (burst == 2'd3) || ((burst == 2'd2) && !len_ok) ||
                (size > MAX_SIZE) || (top >= MEM_BYTES);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------- write channel ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  wstate_t           wstate;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len;
  logic [7:0]        w_cnt;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic              w_bad;
  logic              w_lerr;

  logic w_beat;
  logic w_final;
  logic w_lerr_now;
  logic mem_we;

  assign w_beat     = wvalid && wready;
  assign w_final    = (w_cnt == w_len);
  // The beat counter ends the burst; wlast is only checked against it.
  assign w_lerr_now = w_lerr || (wlast != w_final);
  assign mem_we     = w_beat && !w_bad && arst;

  always_ff @(posedge aclk) begin
    if (!arst) begin
      wstate  <= W_IDLE;
      awready <= 1'b1;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= RESP_OKAY;
      w_cnt   <= '0;
      w_bad   <= 1'b0;
      w_lerr  <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (awvalid && awready) begin
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_size  <= awsize;
            w_burst <= awburst;
            w_bad   <= burst_bad(awaddr, awlen, awsize, awburst);
            w_cnt   <= '0;
            w_lerr  <= 1'b0;
            bid     <= awid;
            awready <= 1'b0;
            wready  <= 1'b1;
            wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            w_cnt  <= w_cnt + 8'd1;
            w_lerr <= w_lerr_now;
            if (w_final) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bresp  <= (w_bad || w_lerr_now) ? RESP_SLVERR : RESP_OKAY;
              wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wstate  <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Byte-enabled array write; contents survive reset.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  rstate_t           rstate;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic [7:0]        r_cnt;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic              r_bad;

  logic              ar_bad;
  logic [ADDR_W-1:0] r_nxt;

  assign ar_bad = burst_bad(araddr, arlen, arsize, arburst);
  assign r_nxt  = next_addr(r_addr, r_len, r_size, r_burst);

  // The array is sampled in this block at the same edge the write block
  // updates it, so a colliding read sees the pre-write word.
  always_ff @(posedge aclk) begin
    if (!arst) begin
      rstate  <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= '0;
      rresp   <= RESP_OKAY;
      rdata   <= '0;
      r_cnt   <= '0;
      r_bad   <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (arvalid && arready) begin
            r_addr  <= araddr;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= arburst;
            r_bad   <= ar_bad;
            r_cnt   <= '0;
            rid     <= arid;
            rvalid  <= 1'b1;
            rlast   <= (arlen == 8'd0);
            rresp   <= ar_bad ? RESP_SLVERR : RESP_OKAY;
            rdata   <= ar_bad ? '0 : mem[word_idx(araddr)];
            arready <= 1'b0;
            rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              rstate  <= R_IDLE;
            end else begin
              r_addr <= r_nxt;
              r_cnt  <= r_cnt + 8'd1;
              rlast  <= ((r_cnt + 8'd1) == r_len);
              rdata  <= r_bad ? '0 : mem[word_idx(r_nxt)];
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule
